// File: rtl/bus_controller_if.sv
// CPU6 address/data bus and byte-wide RAM port, as seen by bus_controller.
// master = CPU core plus RAM side, slave = the controller.
interface bus_controller_if;
    logic [15:0] cpu_address;
    logic        cpu_write_en;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_data_in;
    logic [10:0] ram_address;
    logic        ram_write_en;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;

    modport master (
        output cpu_address, cpu_write_en, cpu_data_out, ram_data_out,
        input  cpu_data_in, ram_address, ram_write_en, ram_data_in
    );

    modport slave (
        input  cpu_address, cpu_write_en, cpu_data_out, ram_data_out,
        output cpu_data_in, ram_address, ram_write_en, ram_data_in
    );
endinterface

// File: rtl/bus_controller.sv
// CPU6 address decoder: RAM, reset-vector ROM, buffered serial TX and halt latch.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high), then next byte or IDLE
module bus_controller #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic             clock,
    input  logic             reset,
    bus_controller_if.slave  bus,
    output logic             uart_tx,
    output logic             halt
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("bus_controller: CLKS_PER_BIT must be >= 2, FIFO_DEPTH a power of two >= 2");
    end

    logic sel_ram, sel_tx, sel_stat, sel_halt;
    logic push, push_ok, push_drop, pop;
    logic fifo_empty, fifo_full;
    logic [7:0] head;
    logic overflow, tx_busy;

    tx_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0] bit_idx, bit_nx;
    logic [7:0] shift, shift_nx;

    assign sel_ram  = (bus.cpu_address[15:11] == 5'd0);
    assign sel_tx   = (bus.cpu_address == 16'hF200);
    assign sel_stat = (bus.cpu_address == 16'hF201);
    assign sel_halt = (bus.cpu_address == 16'hF900);

    assign bus.ram_address  = bus.cpu_address[10:0];
    assign bus.ram_data_in  = bus.cpu_data_out;
    assign bus.ram_write_en = reset & bus.cpu_write_en & sel_ram;

    assign tx_busy = (state != IDLE) | ~fifo_empty;

    always_comb begin
        bus.cpu_data_in = bus.ram_data_out;
        case (bus.cpu_address)
            16'hFD00: bus.cpu_data_in = 8'h71;
            16'hFD01: bus.cpu_data_in = 8'h80;
            16'hFD02: bus.cpu_data_in = 8'h01;
            16'hF200: bus.cpu_data_in = 8'h00;
            16'hF201: bus.cpu_data_in = {5'b0, overflow, fifo_full, tx_busy};
            default:  bus.cpu_data_in = bus.ram_data_out;
        endcase
    end

    // A pop on the same edge frees a slot, so a push into a full buffer still lands.
    assign push      = bus.cpu_write_en & sel_tx;
    assign push_ok   = push & (~fifo_full | pop);
    assign push_drop = push & fifo_full & ~pop;

`ifdef UART_TX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign head       = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= bus.cpu_data_out;
    end
`else
    logic [7:0] hold;
    logic       hold_valid;

    assign fifo_empty = ~hold_valid;
    assign fifo_full  = hold_valid;
    assign head       = hold;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold       <= 8'h00;
            hold_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                hold       <= bus.cpu_data_out;
                hold_valid <= 1'b1;
            end else if (pop) begin
                hold_valid <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            halt     <= 1'b0;
        end else begin
            if (bus.cpu_write_en & sel_stat) overflow <= 1'b0;
            else if (push_drop)              overflow <= 1'b1;
            if (bus.cpu_write_en & sel_halt & (bus.cpu_data_out == 8'h01)) halt <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            shift   <= shift_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_idx;
        shift_nx = shift;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_nx = head;
                    cnt_nx   = CNT_LOAD;
                    state_nx = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    cnt_nx   = CNT_LOAD;
                    bit_nx   = 3'd0;
                    state_nx = DATA;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_nx = CNT_LOAD;
                    if (bit_idx == 3'd7) state_nx = STOP;
                    else                 bit_nx   = bit_idx + 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    // Chain straight into the next start bit so frames have no idle gap.
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_nx = head;
                        cnt_nx   = CNT_LOAD;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        case (state)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = shift[bit_idx];
            default: uart_tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_bus_controller.sv
// Directed bench for bus_controller: ROM/RAM decode, serial frames, overflow, halt, reset.
module tb_bus_controller;
    localparam int CPB = 4;
`ifdef UART_TX_FIFO_EN
    localparam int EXP_FRAMES = 9;
`else
    localparam int EXP_FRAMES = 2;
`endif

    logic clock;
    logic reset;
    logic uart_tx;
    logic halt;
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   stop_err = 0;
    logic [7:0] rx_q [$];
    int         rx_start_q [$];
    logic [7:0] ram [2048];

    bus_controller_if bus ();

    bus_controller #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .uart_tx (uart_tx),
        .halt    (halt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.ram_write_en) ram[bus.ram_address] <= bus.ram_data_in;
    end
    assign bus.ram_data_out = ram[bus.ram_address];

    // Line receiver: detects a start bit and samples each bit mid-cell.
    initial begin : rx_mon
        logic [7:0] b;
        b = 8'h00;
        forever begin
            @(negedge clock);
            if (reset && uart_tx == 1'b0) begin
                rx_start_q.push_back(cyc);
                repeat (CPB + CPB/2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    b[i] = uart_tx;
                    if (i < 7) repeat (CPB) @(negedge clock);
                end
                repeat (CPB) @(negedge clock);
                if (uart_tx !== 1'b1) stop_err++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic exp_we);
        @(negedge clock);
        bus.cpu_address  = a;
        bus.cpu_data_out = d;
        bus.cpu_write_en = 1'b1;
        #1 chk("ram_we", 32'(bus.ram_write_en), 32'(exp_we));
        @(posedge clock);
        #1 bus.cpu_write_en = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        bus.cpu_address = a;
        #1 d = bus.cpu_data_in;
    endtask

    initial begin
        logic [7:0] d;
        logic [9:0] fr;
        int lows;
        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
        reset = 1'b0;
        bus.cpu_address  = 16'h0105;
        bus.cpu_data_out = 8'hEE;
        bus.cpu_write_en = 1'b1;
        #2;
        chk("rst ram_we", 32'(bus.ram_write_en), 32'd0);
        chk("rst uart_tx", 32'(uart_tx), 32'd1);
        chk("rst halt", 32'(halt), 32'd0);
        bus.cpu_write_en = 1'b0;
        rd(16'hF201, d);
        chk("rst status", 32'(d), 32'h00);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        rd(16'hFD00, d); chk("boot fd00", 32'(d), 32'h71);
        rd(16'hFD01, d); chk("boot fd01", 32'(d), 32'h80);
        rd(16'hFD02, d); chk("boot fd02", 32'(d), 32'h01);
        rd(16'hF200, d); chk("rd f200", 32'(d), 32'h00);
        wr(16'hFD00, 8'h99, 1'b0);

        wr(16'h0105, 8'h5A, 1'b1);
        rd(16'h0105, d); chk("ram rd", 32'(d), 32'h5A);
        rd(16'h0905, d); chk("ram alias rd", 32'(d), 32'h5A);
        wr(16'h0905, 8'h11, 1'b0);
        rd(16'h0105, d); chk("ram unchanged", 32'(d), 32'h5A);
        wr(16'h07FF, 8'hC3, 1'b1);
        rd(16'h07FF, d); chk("ram top", 32'(d), 32'hC3);

        // Single byte: start bit from edge N+1, frame of 10*CPB cycles.
        wr(16'hF200, 8'h41, 1'b0);
        chk("tx before N+1", 32'(uart_tx), 32'd1);
        fr = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < 10*CPB; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k % CPB == 1) chk($sformatf("frame bit %0d", k / CPB), 32'(uart_tx), 32'(fr[k / CPB]));
        end
        @(posedge clock);
        @(negedge clock);
        chk("tx after frame", 32'(uart_tx), 32'd1);
        rd(16'hF201, d);
        chk("idle status", 32'(d), 32'h00);
        rx_q.delete();
        rx_start_q.delete();

        for (int i = 0; i < 10; i++) wr(16'hF200, 8'(8'h30 + i), 1'b0);
        rd(16'hF201, d); chk("ovf status", 32'(d), 32'h07);
        wr(16'hF201, 8'hFF, 1'b0);
        rd(16'hF201, d); chk("ovf cleared", 32'(d), 32'h03);
        for (int t = 0; t < (EXP_FRAMES + 1) * 10 * CPB + 50 && rx_q.size() < EXP_FRAMES; t++)
            @(negedge clock);
        chk("frames received", 32'(rx_q.size()), 32'(EXP_FRAMES));
        repeat (100) @(negedge clock);
        chk("no extra frame", 32'(rx_q.size()), 32'(EXP_FRAMES));
        for (int i = 0; i < EXP_FRAMES; i++) begin
            if (i < rx_q.size()) chk($sformatf("rx byte %0d", i), 32'(rx_q[i]), 32'(8'h30 + i));
            if (i > 0 && i < rx_start_q.size())
                chk($sformatf("frame gap %0d", i), 32'(rx_start_q[i] - rx_start_q[i-1]), 32'(10*CPB));
        end
        chk("stop bits", 32'(stop_err), 32'd0);
        rd(16'hF201, d); chk("drained status", 32'(d), 32'h00);

        wr(16'hF900, 8'h02, 1'b0);
        chk("halt ignores 02", 32'(halt), 32'd0);
        @(negedge clock);
        bus.cpu_address  = 16'hF900;
        bus.cpu_data_out = 8'h01;
        bus.cpu_write_en = 1'b1;
        #1 chk("halt before edge", 32'(halt), 32'd0);
        @(posedge clock);
        #1 bus.cpu_write_en = 1'b0;
        chk("halt set", 32'(halt), 32'd1);
        wr(16'hF900, 8'h00, 1'b0);
        wr(16'h0010, 8'h01, 1'b1);
        chk("halt sticky", 32'(halt), 32'd1);

        // Reset in the middle of data bit 3 with a second byte still queued.
        wr(16'hF200, 8'hA5, 1'b0);
        wr(16'hF200, 8'h5A, 1'b0);
        repeat (17) @(posedge clock);
        @(negedge clock);
        chk("bit3 before reset", 32'(uart_tx), 32'd0);
        reset = 1'b0;
        #1 chk("rst mid tx", 32'(uart_tx), 32'd1);
        rd(16'hF201, d); chk("rst mid status", 32'(d), 32'h00);
        chk("rst mid halt", 32'(halt), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (60) @(negedge clock);
        rx_q.delete();
        rx_start_q.delete();
        lows = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("no tx after reset", 32'(lows), 32'd0);
        chk("no frame after reset", 32'(rx_q.size()), 32'd0);
        rd(16'hF201, d); chk("post reset status", 32'(d), 32'h00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_controller.md
# bus_controller

Address decoder and I/O sequencer between the CPU6 core and its byte-wide single-port RAM. It routes CPU reads and writes to RAM, the reset-vector ROM, a serial transmit port and a simulation halt latch. It replaces ad-hoc decoding with one owned block that buffers console output and serializes it at a fixed bit rate. It sits directly on the CPU6 address, data and write-enable bus.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit (≥2)
- FIFO_DEPTH, 8, TX FIFO entries (power of two, ≥2)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_address  in  16  CPU address bus
- cpu_write_en  in  1  CPU write strobe, sampled on the rising edge
- cpu_data_out  in  8  CPU write data
- cpu_data_in  out  8  read data returned to the CPU (combinational)
- ram_address  out  11  equals cpu_address[10:0]
- ram_write_en  out  1  RAM write strobe
- ram_data_in  out  8  equals cpu_data_out
- ram_data_out  in  8  RAM read data, combinational
- uart_tx  out  1  serial line, idle high
- halt  out  1  sticky simulation-stop flag

## Operation
- Read map (combinational on cpu_address):
  - FD00/FD01/FD02 → 0x71/0x80/0x01 (JMP 8001).
  - F200 → 0x00.
  - F201 → status {5'b0, overflow, fifo_full, tx_busy}.
  - All other addresses → ram_data_out (11-bit alias).
- Write map:
  - 0x0000–0x07FF → ram_write_en = cpu_write_en. ram_write_en is 0 for every other address and while reset is asserted.
  - F200 → push cpu_data_out into the TX FIFO.
  - F201 → clear overflow; data is ignored.
  - F900 with data 0x01 → set halt. Any other data is ignored.
  - Writes elsewhere are discarded.
- TX FIFO:
  - Circular buffer with a count of 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - A push while full is dropped and sets overflow (sticky).
  - A push and pop on the same edge while full: the pop frees a slot and the push is accepted, so overflow is not set.
  - A push and pop on the same edge while empty is impossible, because a pop requires a non-empty FIFO.
- TX FSM states are IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop its head into the shift register on the next edge and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, tracked by a 3-bit bit index.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then pop the next byte directly into START if the FIFO is non-empty, otherwise go to IDLE. Back-to-back frames therefore have no idle gap.
- tx_busy = (state≠IDLE) or FIFO non-empty.
- halt stays set until reset.

## Timing
- Reset values:
  - uart_tx=1, halt=0, overflow=0.
  - FIFO empty, state IDLE, counters 0.
  - ram_write_en=0.
- Reset takes effect asynchronously, including mid-frame: uart_tx goes high immediately and queued bytes are lost.
- A write at edge N is visible in the FIFO and status after edge N.
- Pop and START entry occur at edge N+1. uart_tx falls after edge N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- halt rises after the write edge.
- Read paths have zero latency (combinational).

## Configuration
- UART_TX_FIFO_EN defined: TX buffer is the FIFO_DEPTH-entry FIFO described above.
- UART_TX_FIFO_EN undefined:
  - The TX buffer is a single holding register and FIFO_DEPTH is ignored.
  - fifo_full = holding register occupied.
  - Overflow, same-edge push/pop and status rules are unchanged, with depth 1.

## Test plan
- Boot vector: read FD00, FD01, FD02 → cpu_data_in 0x71, 0x80, 0x01. A write to FD00 leaves ram_write_en=0.
- RAM path: write 0x5A to 0x0105, then read 0x0105 → 0x5A. A write to 0x0905 → ram_write_en=0.
- Single byte, CLKS_PER_BIT=4: write 0x41 to F200 at edge N.
  - uart_tx low from edge N+1 for 4 cycles, then bits 1,0,0,0,0,0,1,0, then high.
  - Frame is 40 cycles total.
  - tx_busy=0 after the frame.
- Overflow: 10 writes to F200 (0x30..0x39) on consecutive edges, FIFO_DEPTH=8.
  - The 10th byte (0x39) is dropped and F201 reads 0x07.
  - Exactly 9 contiguous frames follow.
  - A write to F201 clears bit 2.
- Halt: write 0x02 to F900 → halt stays 0. Write 0x01 → halt=1 after that edge; it stays 1 through later writes.
- Reset mid-frame: assert reset during DATA bit 3 → uart_tx=1 immediately, status 0x00. After release, no further frames are sent.
